// File: rtl/odo_div_ctrl.sv
// rtl/odo_div_ctrl.sv - sequencing and ratio control for the odd/even clock divider
module odo_div_ctrl #(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 9,
  parameter int MIN_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic [CNT_W-1:0] div_cnt,
  output logic             clkp,
  output logic             odd_mode,
  output logic             period_start,
  output logic [CNT_W-1:0] active_div,
  output logic             busy
);

  typedef enum logic [1:0] {ST_STOP = 2'd0, ST_RUN = 2'd1, ST_PEND = 2'd2} state_t;

  localparam logic [CNT_W-1:0] DEF_V = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] MIN_V = CNT_W'(MIN_DIV);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] pend_div;
  logic [CNT_W-1:0] cnt_nxt, div_nxt, pend_nxt;
  logic             err_nxt, clkp_nxt, ps_nxt, running_nxt;
  logic             accept, legal, wrap;

  // Handshake and period-boundary decode shared by the FSM and datapath
  assign accept = cfg_valid & cfg_ready;
  assign legal  = (cfg_div >= MIN_V);
  assign wrap   = (div_cnt == active_div - CNT_W'(1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_STOP;
    else     state <= state_nxt;
  end

  // Next-state: run/stop and ratio switches only take effect on the wrap cycle
  always_comb begin
    state_nxt = state;
    case (state)
      ST_STOP: if (en) state_nxt = ST_RUN;
      ST_RUN: begin
        if (wrap)                 state_nxt = en ? ST_RUN : ST_STOP;
        else if (accept && legal) state_nxt = ST_PEND;
      end
      ST_PEND: if (wrap) state_nxt = en ? ST_RUN : ST_STOP;
      default: state_nxt = ST_STOP;
    endcase
  end

  // Output decode: next values of the registered outputs, plus the unregistered cfg_ready
  always_comb begin
    cfg_ready = ~rst && (state != ST_PEND);
    cnt_nxt   = div_cnt;
    div_nxt   = active_div;
    pend_nxt  = pend_div;
    err_nxt   = accept && !legal;
    case (state)
      ST_STOP: begin
        cnt_nxt = '0;
        if (accept && legal) div_nxt = cfg_div;
      end
      ST_RUN: begin
        cnt_nxt = wrap ? '0 : div_cnt + CNT_W'(1);
        if (accept && legal) begin
          if (wrap) div_nxt  = cfg_div;
          else      pend_nxt = cfg_div;
        end
      end
      ST_PEND: begin
        cnt_nxt = wrap ? '0 : div_cnt + CNT_W'(1);
        if (wrap) div_nxt = pend_div;
      end
      default: cnt_nxt = '0;
    endcase
    // The high phase is computed against the ratio of the cycle being entered,
    // so a new ratio shapes its first period from div_cnt = 0
    running_nxt = (state_nxt != ST_STOP);
    clkp_nxt    = running_nxt && (cnt_nxt < (div_nxt >> 1));
    ps_nxt      = running_nxt && (cnt_nxt == '0);
  end

  // Datapath registers; reset drops any pending ratio
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt      <= '0;
      clkp         <= 1'b0;
      period_start <= 1'b0;
      cfg_err      <= 1'b0;
      active_div   <= DEF_V;
      odd_mode     <= DEF_V[0];
      pend_div     <= DEF_V;
      busy         <= 1'b0;
    end else begin
      div_cnt      <= cnt_nxt;
      clkp         <= clkp_nxt;
      period_start <= ps_nxt;
      cfg_err      <= err_nxt;
      active_div   <= div_nxt;
      odd_mode     <= div_nxt[0];
      pend_div     <= pend_nxt;
      busy         <= running_nxt;
    end
  end

endmodule

// File: tb/tb_odo_div_ctrl.sv
// tb/tb_odo_div_ctrl.sv - directed self-checking bench for odo_div_ctrl
module tb_odo_div_ctrl;

  logic       clk = 1'b0;
  logic       rst, en, cfg_valid;
  logic [7:0] cfg_div;
  logic       cfg_ready, cfg_err, clkp, odd_mode, period_start, busy;
  logic [7:0] div_cnt, active_div;

  int checks = 0;
  int errors = 0;

  odo_div_ctrl #(.CNT_W(8), .DEF_DIV(9), .MIN_DIV(2)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err), .div_cnt(div_cnt), .clkp(clkp),
    .odd_mode(odd_mode), .period_start(period_start), .active_div(active_div),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Clock until div_cnt shows the target; a missed target counts as a failure
  task automatic advance_to(input int target);
    int n = 0;
    while (div_cnt !== 8'(target) && n < 300) begin
      step();
      n++;
    end
    chk("advance_to", int'(div_cnt), target);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = 8'd0;

    // Reset
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_cnt", div_cnt, 0);
      chk("rst_clkp", clkp, 0);
      chk("rst_ps", period_start, 0);
      chk("rst_err", cfg_err, 0);
      chk("rst_div", active_div, 9);
      chk("rst_odd", odd_mode, 1);
      chk("rst_busy", busy, 0);
      chk("rst_ready", cfg_ready, 0);
    end
    rst = 1'b0; en = 1'b1;
    #1 chk("stop_ready", cfg_ready, 1);

    // Default run, N = 9: two full periods
    for (int i = 0; i < 18; i++) begin
      step();
      chk("run9_cnt", div_cnt, i % 9);
      chk("run9_clkp", clkp, (i % 9) < 4 ? 1 : 0);
      chk("run9_ps", period_start, (i % 9) == 0 ? 1 : 0);
      chk("run9_busy", busy, 1);
    end
    chk("run9_odd", odd_mode, 1);

    // Mid-period update to 4 at div_cnt = 3
    advance_to(3);
    cfg_valid = 1'b1; cfg_div = 8'd4;
    step();
    cfg_valid = 1'b0;
    for (int c = 4; c <= 8; c++) begin
      chk("pend_cnt", div_cnt, c);
      chk("pend_ready", cfg_ready, 0);
      chk("pend_busy", busy, 1);
      chk("pend_div", active_div, 9);
      if (c < 8) step();
    end
    step();
    chk("n4_cnt", div_cnt, 0);
    chk("n4_div", active_div, 4);
    chk("n4_odd", odd_mode, 0);
    chk("n4_ps", period_start, 1);
    chk("n4_ready", cfg_ready, 1);
    chk("n4_clkp0", clkp, 1);
    step(); chk("n4_clkp1", clkp, 1);
    step(); chk("n4_clkp2", clkp, 0);
    step(); chk("n4_clkp3", clkp, 0); chk("n4_cnt3", div_cnt, 3);
    step(); chk("n4_wrap", div_cnt, 0); chk("n4_clkp_w", clkp, 1);

    // Wrap-cycle updates: back to 9 at cnt 3, then 5 at cnt 8
    advance_to(3);
    cfg_valid = 1'b1; cfg_div = 8'd9;
    step();
    cfg_valid = 1'b0;
    chk("w9_cnt", div_cnt, 0);
    chk("w9_div", active_div, 9);
    chk("w9_ready", cfg_ready, 1);
    advance_to(8);
    cfg_valid = 1'b1; cfg_div = 8'd5;
    step();
    cfg_valid = 1'b0;
    chk("w5_cnt", div_cnt, 0);
    chk("w5_div", active_div, 5);
    chk("w5_ready", cfg_ready, 1);
    step();
    chk("w5_ready2", cfg_ready, 1);
    chk("w5_cnt1", div_cnt, 1);

    // Illegal ratio 1
    cfg_valid = 1'b1; cfg_div = 8'd1;
    step();
    cfg_valid = 1'b0;
    chk("ill_err", cfg_err, 1);
    chk("ill_div", active_div, 5);
    chk("ill_cnt", div_cnt, 2);
    chk("ill_ready", cfg_ready, 1);
    step();
    chk("ill_err_off", cfg_err, 0);
    chk("ill_cnt2", div_cnt, 3);
    chk("ill_div2", active_div, 5);

    // Back to 9, then stop and restart
    advance_to(4);
    cfg_valid = 1'b1; cfg_div = 8'd9;
    step();
    cfg_valid = 1'b0;
    chk("r9_div", active_div, 9);
    advance_to(2);
    en = 1'b0;
    advance_to(8);
    chk("stop_busy_pre", busy, 1);
    step();
    chk("stop_cnt", div_cnt, 0);
    chk("stop_clkp", clkp, 0);
    chk("stop_busy", busy, 0);
    chk("stop_ps", period_start, 0);
    step();
    chk("stop_hold", busy, 0);
    chk("stop_hold_cnt", div_cnt, 0);
    en = 1'b1;
    step();
    chk("restart_ps", period_start, 1);
    chk("restart_busy", busy, 1);
    chk("restart_clkp", clkp, 1);

    // Reset while a ratio is pending
    advance_to(1);
    cfg_valid = 1'b1; cfg_div = 8'd4;
    step();
    cfg_valid = 1'b0;
    chk("rp_ready", cfg_ready, 0);
    advance_to(5);
    rst = 1'b1;
    step();
    chk("rp_div", active_div, 9);
    chk("rp_busy", busy, 0);
    chk("rp_ready_rst", cfg_ready, 0);
    rst = 1'b0;
    step();
    chk("rp_run_cnt", div_cnt, 0);
    advance_to(8);
    step();
    chk("rp_after_wrap", active_div, 9);
    chk("rp_after_cnt", div_cnt, 0);

    // Smallest legal ratio, N = 2
    advance_to(8);
    cfg_valid = 1'b1; cfg_div = 8'd2;
    step();
    cfg_valid = 1'b0;
    chk("n2_div", active_div, 2);
    chk("n2_clkp0", clkp, 1);
    step();
    chk("n2_cnt1", div_cnt, 1);
    chk("n2_clkp1", clkp, 0);
    step();
    chk("n2_cnt0", div_cnt, 0);
    chk("n2_ps", period_start, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
